// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register sitting in front of a 256-byte,
// big-endian, combinational-read data memory. A head entry drives the memory
// and write-back outputs; a skid entry absorbs one extra bundle while WB is
// stalled so EX sees back-pressure one cycle late. Misaligned or out-of-range
// accesses are flagged at capture and suppressed at the memory/register file.
module ex_mem_stage (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,

    input  logic        flush,

    output logic        MemRead,
    output logic        MemWrite,
    output logic [7:0]  ALUout,
    output logic [31:0] Data2,
    input  logic [31:0] ReadData,

    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        addr_err
);

    // Occupancy of the two-entry buffer.
    localparam logic [1:0] ST_EMPTY = 2'd0;  // no valid entry
    localparam logic [1:0] ST_ONE   = 2'd1;  // head only
    localparam logic [1:0] ST_TWO   = 2'd2;  // head + skid

    // Highest byte address at which a full word still fits in memory.
    localparam logic [7:0] LAST_WORD_ADDR = 8'd252;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        fault;
    } entry_t;

    logic [1:0] state;
    logic [1:0] state_next;
    entry_t     head;
    entry_t     head_next;
    entry_t     skid;
    entry_t     skid_next;
    entry_t     incoming;
    logic       accept;
    logic       drain;

    // Package the EX bundle and classify it as faulting before it is stored.
    always_comb begin
        incoming.alu_result = ex_alu_result;
        incoming.store_data = ex_store_data;
        incoming.rd         = ex_rd;
        incoming.mem_read   = ex_mem_read;
        incoming.mem_write  = ex_mem_write;
        incoming.reg_write  = ex_reg_write;
        incoming.mem_to_reg = ex_mem_to_reg;
        incoming.fault      = (ex_mem_read | ex_mem_write) &
                              ((ex_alu_result[1:0] != 2'b00) |
                               (ex_alu_result[31:8] != 24'd0) |
                               (ex_alu_result[7:0] > LAST_WORD_ADDR));
    end

    assign wb_valid = (state != ST_EMPTY);
    assign accept   = ex_valid & ex_ready;
    assign drain    = wb_valid & wb_ready;

    // Next occupancy and entry contents; flush empties the buffer and zeroes
    // the head so the memory address/data outputs read back as 0.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold it.
        state_next = state;
        head_next  = head;
        skid_next  = skid;
        if (flush) begin
            state_next = ST_EMPTY;
            head_next  = '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next = ST_ONE;
                        head_next  = incoming;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        head_next = incoming;
                    end else if (accept) begin
                        state_next = ST_TWO;
                        skid_next  = incoming;
                    end else if (drain) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // ex_ready is low here, so only a drain can happen.
                    if (drain) begin
                        state_next = ST_ONE;
                        head_next  = skid;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy, head entry and the registered ready; all cleared by reset.
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state    <= ST_EMPTY;
            head     <= '0;
            ex_ready <= 1'b1;
        end else begin
            state    <= state_next;
            head     <= head_next;
            ex_ready <= (state_next != ST_TWO);
        end
    end

    // Skid payload; only meaningful while state is ST_TWO.
    always_ff @(posedge clock) begin
        // NOTE: the skid payload has no reset; its validity lives in state,
        // so stale contents are never observed and the reset net stays small.
        skid <= skid_next;
    end

    // A store writes only on its drain edge, and never in a flush or reset
    // cycle, so a stalled store reaches memory exactly once.
    assign MemWrite     = reset_n & drain & head.mem_write & ~head.fault & ~flush;
    assign MemRead      = wb_valid & head.mem_read & ~head.fault;
    assign ALUout       = head.alu_result[7:0];
    assign Data2        = head.store_data;

    assign wb_reg_write = wb_valid & head.reg_write & ~head.fault;
    assign wb_rd        = head.rd;
    assign wb_data      = head.mem_to_reg ? ReadData : head.alu_result;
    assign addr_err     = wb_valid & head.fault;

endmodule
